machine_timer: RTL and testbench

Memory-mapped RISC-V machine timer (mtime/mtimecmp) that feeds the `timer_timeout` input of the core's control FSM. It counts a 64-bit `mtime` driven by a programmable prescaler while the design is enabled. It compares `mtime` against a 64-bit `mtimecmp` and raises a registered, level-sensitive timeout. Software programs it through a simple word-wide register port driven by the load/store stage.

---
 rtl/machine_timer.sv | 168 ++++++++++++++++
 tb/tb_machine_timer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V machine timer (mtime / mtimecmp).
// A 64-bit mtime advances on prescaler ticks while run && count_en, and a
// registered level timeout is raised whenever mtime >= mtimecmp.
// Optional build macro TIMER_CMP_ATOMIC_EN: a write to mtimecmp_lo masks the
// compare until the matching mtimecmp_hi write, so a half-updated compare
// value never fires.

`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module machine_timer #(
  parameter int PRESCALE_DIV = 1,
  parameter int ADDR_W       = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   count_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [`size_X_LEN-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [`size_X_LEN-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   timer_timeout
);

  localparam int XLEN   = `size_X_LEN;
  localparam int WORD_W = ADDR_W - 2;

  localparam logic [15:0]       PRE_LAST     = 16'(PRESCALE_DIV - 1);
  localparam logic [WORD_W-1:0] A_MTIME_LO   = WORD_W'(0);
  localparam logic [WORD_W-1:0] A_MTIME_HI   = WORD_W'(1);
  localparam logic [WORD_W-1:0] A_MTIMECMP_LO = WORD_W'(2);
  localparam logic [WORD_W-1:0] A_MTIMECMP_HI = WORD_W'(3);
  localparam logic [WORD_W-1:0] A_CTRL       = WORD_W'(4);

  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic            r_run;
  logic [15:0]     r_pre;
  logic            r_timeout;
  logic [XLEN-1:0] r_rd_data;
  logic            r_rd_valid;

  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_wr_mtime_lo;
  logic              w_wr_mtime_hi;
  logic              w_wr_cmp_lo;
  logic              w_wr_cmp_hi;
  logic              w_wr_ctrl;
  logic              w_en;
  logic              w_tick;
  logic [63:0]       w_mtime_nxt;
  logic              w_hit;
  logic [XLEN-1:0]   w_rd_mux;
  logic              w_unused_addr_lsb;

  // Byte offsets select a word; the two low address bits carry no meaning.
  assign w_wr_word         = wr_addr[ADDR_W-1:2];
  assign w_rd_word         = rd_addr[ADDR_W-1:2];
  assign w_unused_addr_lsb = ^{wr_addr[1:0], rd_addr[1:0]};

  assign w_wr_mtime_lo = wr_en && (w_wr_word == A_MTIME_LO);
  assign w_wr_mtime_hi = wr_en && (w_wr_word == A_MTIME_HI);
  assign w_wr_cmp_lo   = wr_en && (w_wr_word == A_MTIMECMP_LO);
  assign w_wr_cmp_hi   = wr_en && (w_wr_word == A_MTIMECMP_HI);
  assign w_wr_ctrl     = wr_en && (w_wr_word == A_CTRL);

  assign w_en   = r_run && count_en;
  assign w_tick = w_en && (r_pre == PRE_LAST);

  // Full 64-bit increment from the old value; a half-write below replaces
  // only its own half, so the other half still takes the carry.
  assign w_mtime_nxt = w_tick ? (r_mtime + 64'd1) : r_mtime;

  // Prescale counter: advances while enabled, wraps on tick, holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_wr_ctrl || w_tick) begin
      r_pre <= '0;
    end else if (w_en) begin
      r_pre <= r_pre + 16'd1;
    end
  end

  // mtime: tick increment with per-half software override.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtime <= '0;
    end else begin
      r_mtime[31:0]  <= w_wr_mtime_lo ? wr_data[31:0] : w_mtime_nxt[31:0];
      r_mtime[63:32] <= w_wr_mtime_hi ? wr_data[31:0] : w_mtime_nxt[63:32];
    end
  end

  // mtimecmp and ctrl.run software registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mtimecmp <= '1;
      r_run      <= 1'b0;
    end else begin
      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= wr_data[31:0];
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= wr_data[31:0];
      if (w_wr_ctrl)   r_run             <= wr_data[0];
    end
  end

`ifdef TIMER_CMP_ATOMIC_EN
  logic r_cmp_pending;

  // Track a low-half compare write that still awaits its high half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmp_pending <= 1'b0;
    end else if (w_wr_cmp_hi) begin
      r_cmp_pending <= 1'b0;
    end else if (w_wr_cmp_lo) begin
      r_cmp_pending <= 1'b1;
    end
  end

  assign w_hit = (r_mtime >= r_mtimecmp) && !r_cmp_pending;
`else
  assign w_hit = (r_mtime >= r_mtimecmp);
`endif

  // Timeout is a registered level of the current compare result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_hit;
    end
  end

  // Read mux over the pre-edge register values (read-during-write sees old data).
  always_comb begin
    w_rd_mux = '0;
    case (w_rd_word)
      A_MTIME_LO:    w_rd_mux = r_mtime[31:0];
      A_MTIME_HI:    w_rd_mux = r_mtime[63:32];
      A_MTIMECMP_LO: w_rd_mux = r_mtimecmp[31:0];
      A_MTIMECMP_HI: w_rd_mux = r_mtimecmp[63:32];
      A_CTRL:        w_rd_mux = {{(XLEN-1){1'b0}}, r_run};
      default:       w_rd_mux = '0;
    endcase
  end

  // Registered read port with one-cycle valid strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign timer_timeout = r_timeout;

endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: bench for machine_timer. Two instances (prescale 1 and 4)
// share one stimulus stream and are compared against a 64-bit arithmetic
// reference model of the timer's register behaviour.

module tb_machine_timer;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        count_en;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;

  logic [31:0] drd [2];
  logic        drv [2];
  logic        dto [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  machine_timer #(.PRESCALE_DIV(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .reset(reset), .count_en(count_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(drd[0]), .rd_valid(drv[0]), .timer_timeout(dto[0])
  );

  machine_timer #(.PRESCALE_DIV(4), .ADDR_W(AW)) dut4 (
    .clk(clk), .reset(reset), .count_en(count_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(drd[1]), .rd_valid(drv[1]), .timer_timeout(dto[1])
  );

  // Reference model state
  longint unsigned m_mt [2];
  longint unsigned m_cmp;
  bit              m_run;
  int              m_pre [2];
  bit              m_pend;
  bit              m_to [2];
  logic [31:0]     m_rd [2];
  bit              m_rv;

  function automatic int div_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] m_reg(int k, logic [4:0] a);
    case (a[4:2])
      3'd0:    return m_mt[k][31:0];
      3'd1:    return m_mt[k][63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {31'd0, m_run};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mt[k] = 0; m_pre[k] = 0; m_to[k] = 0; m_rd[k] = 32'd0;
    end
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_run = 0; m_pend = 0; m_rv = 0;
  endtask

  // Advance one clock: predict next state from current inputs, then commit.
  task automatic step();
    longint unsigned n_mt [2];
    int              n_pre [2];
    bit              n_to [2];
    logic [31:0]     n_rd [2];
    longint unsigned n_cmpv;
    bit              n_run, n_pend;
    bit              wlo, whi, wcl, wch, wct;
    wlo = wr_en && (wr_addr[4:2] == 3'd0);
    whi = wr_en && (wr_addr[4:2] == 3'd1);
    wcl = wr_en && (wr_addr[4:2] == 3'd2);
    wch = wr_en && (wr_addr[4:2] == 3'd3);
    wct = wr_en && (wr_addr[4:2] == 3'd4);
    for (int k = 0; k < 2; k++) begin
      bit en, tick;
      en   = m_run && count_en;
      tick = en && (m_pre[k] == div_of(k) - 1);
      n_pre[k] = (wct || tick) ? 0 : (en ? m_pre[k] + 1 : m_pre[k]);
      n_mt[k]  = tick ? m_mt[k] + 1 : m_mt[k];
      if (wlo) n_mt[k] = {n_mt[k][63:32], wr_data};
      if (whi) n_mt[k] = {wr_data, n_mt[k][31:0]};
      n_to[k]  = (m_mt[k] >= m_cmp) && !m_pend;
      n_rd[k]  = rd_en ? m_reg(k, rd_addr) : m_rd[k];
    end
    n_cmpv = m_cmp;
    if (wcl) n_cmpv = {m_cmp[63:32], wr_data};
    if (wch) n_cmpv = {wr_data, m_cmp[31:0]};
    n_run = wct ? wr_data[0] : m_run;
    n_pend = m_pend;
`ifdef TIMER_CMP_ATOMIC_EN
    if (wch) n_pend = 0;
    else if (wcl) n_pend = 1;
`endif
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_mt[k] = n_mt[k]; m_pre[k] = n_pre[k]; m_to[k] = n_to[k]; m_rd[k] = n_rd[k];
    end
    m_cmp = n_cmpv; m_run = n_run; m_pend = n_pend; m_rv = rd_en;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dto[k] !== 1'b0) begin n_bad++; $display("FAIL reset_timeout[%0d]: got %b want 0", k, dto[k]); end
      n_cmp++; if (drv[k] !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid[%0d]: got %b want 0", k, drv[k]); end
      n_cmp++; if (drd[k] !== 32'd0) begin n_bad++; $display("FAIL reset_rd_data[%0d]: got %h want 0", k, drd[k]); end
    end
    reset = 1'b0;
    for (int w = 0; w < 8; w++) begin
      rd(5'(w * 4));
      exp = (w == 2 || w == 3) ? 32'hFFFF_FFFF : 32'd0;
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (drd[k] !== exp) begin n_bad++; $display("FAIL reset_reg%0d[%0d]: got %h want %h", w, k, drd[k], exp); end
        n_cmp++; if (drv[k] !== 1'b1) begin n_bad++; $display("FAIL reset_rdv%0d[%0d]: got %b want 1", w, k, drv[k]); end
      end
    end
  endtask

  task automatic test_count_basic();
    do_reset();
    count_en = 1'b1;
    wr(5'h08, 32'd10);
    wr(5'h0C, 32'd0);
    wr(5'h10, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (dto[k] !== m_to[k]) begin n_bad++; $display("FAIL basic_timeout[%0d] cyc %0d: got %b want %b", k, i, dto[k], m_to[k]); end
      end
    end
    rd(5'h00);
    n_cmp++; if (drd[0] !== 32'd10) begin n_bad++; $display("FAIL basic_mtime_div1: got %0d want 10", drd[0]); end
    n_cmp++; if (drd[1] !== m_rd[1]) begin n_bad++; $display("FAIL basic_mtime_div4: got %0d want %0d", drd[1], m_rd[1]); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (dto[0] !== 1'b1) begin n_bad++; $display("FAIL basic_timeout_hold cyc %0d: got %b want 1", i, dto[0]); end
      step();
    end
  endtask

  task automatic test_prescale();
    do_reset();
    count_en = 1'b1;
    wr(5'h10, 32'd1);
    repeat (20) step();
    count_en = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      rd(5'h00);
      n_cmp++; if (drd[1] !== 32'd5) begin n_bad++; $display("FAIL prescale_div4 pass %0d: got %0d want 5", pass, drd[1]); end
      n_cmp++; if (drd[0] !== 32'd20) begin n_bad++; $display("FAIL prescale_div1 pass %0d: got %0d want 20", pass, drd[0]); end
      repeat (6) step();
    end
    // Prescale phase survives the pause: compare further counting to the model.
    count_en = 1'b1;
    repeat (9) step();
    count_en = 1'b0;
    rd(5'h00);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (drd[k] !== m_rd[k]) begin n_bad++; $display("FAIL prescale_resume[%0d]: got %0d want %0d", k, drd[k], m_rd[k]); end
    end
  endtask

  task automatic test_carry();
    do_reset();
    count_en = 1'b0;
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h10, 32'd1);
    count_en = 1'b1;
    step();
    wr(5'h00, 32'd0);
    count_en = 1'b0;
    rd(5'h00);
    n_cmp++; if (drd[0] !== 32'd0) begin n_bad++; $display("FAIL carry_wr_lo: got %h want 0", drd[0]); end
    n_cmp++; if (drd[1] !== m_rd[1]) begin n_bad++; $display("FAIL carry_wr_lo_div4: got %h want %h", drd[1], m_rd[1]); end
    rd(5'h04);
    n_cmp++; if (drd[0] !== 32'd1) begin n_bad++; $display("FAIL carry_wr_hi: got %h want 1", drd[0]); end
    n_cmp++; if (drd[1] !== m_rd[1]) begin n_bad++; $display("FAIL carry_wr_hi_div4: got %h want %h", drd[1], m_rd[1]); end
    // Plain carry across the 32-bit boundary.
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'd0);
    count_en = 1'b1;
    step();
    count_en = 1'b0;
    rd(5'h04);
    n_cmp++; if (drd[0] !== 32'd1) begin n_bad++; $display("FAIL carry_plain_hi: got %h want 1", drd[0]); end
    rd(5'h00);
    n_cmp++; if (drd[0] !== 32'd0) begin n_bad++; $display("FAIL carry_plain_lo: got %h want 0", drd[0]); end
    // Full 64-bit wrap to zero.
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'hFFFF_FFFF);
    count_en = 1'b1;
    step();
    count_en = 1'b0;
    rd(5'h00);
    n_cmp++; if (drd[0] !== 32'd0) begin n_bad++; $display("FAIL wrap_lo: got %h want 0", drd[0]); end
    rd(5'h04);
    n_cmp++; if (drd[0] !== 32'd0) begin n_bad++; $display("FAIL wrap_hi: got %h want 0", drd[0]); end
    n_cmp++; if (drd[1] !== m_rd[1]) begin n_bad++; $display("FAIL wrap_hi_div4: got %h want %h", drd[1], m_rd[1]); end
  endtask

  task automatic test_timeout_clear();
    do_reset();
    count_en = 1'b0;
    wr(5'h00, 32'd50);
    wr(5'h08, 32'd20);
    wr(5'h0C, 32'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dto[k] !== 1'b1) begin n_bad++; $display("FAIL clear_pre[%0d]: got %b want 1", k, dto[k]); end
    end
    wr(5'h0C, 32'hFFFF_FFFF);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dto[k] !== 1'b1) begin n_bad++; $display("FAIL clear_write_edge[%0d]: got %b want 1", k, dto[k]); end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dto[k] !== 1'b0) begin n_bad++; $display("FAIL clear_after[%0d]: got %b want 0", k, dto[k]); end
    end
  endtask

  task automatic test_atomic();
    logic exp_lo;
`ifdef TIMER_CMP_ATOMIC_EN
    exp_lo = 1'b0;
`else
    exp_lo = 1'b1;
`endif
    do_reset();
    count_en = 1'b0;
    wr(5'h00, 32'h100);
    wr(5'h0C, 32'd0);
    step();
    n_cmp++; if (dto[0] !== 1'b0) begin n_bad++; $display("FAIL atomic_pre: got %b want 0", dto[0]); end
    wr(5'h08, 32'd0);
    step();
    n_cmp++; if (dto[0] !== exp_lo) begin n_bad++; $display("FAIL atomic_after_lo: got %b want %b", dto[0], exp_lo); end
    wr(5'h0C, 32'd0);
    n_cmp++; if (dto[0] !== exp_lo) begin n_bad++; $display("FAIL atomic_hi_edge: got %b want %b", dto[0], exp_lo); end
    step();
    n_cmp++; if (dto[0] !== 1'b1) begin n_bad++; $display("FAIL atomic_after_hi: got %b want 1", dto[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old;
    count_en = 1'b1;
    wr(5'h10, 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd_addr = 5'(i * 4);
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (drv[k] !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d[%0d]: got %b want 1", i, k, drv[k]); end
        n_cmp++; if (drd[k] !== m_rd[k]) begin n_bad++; $display("FAIL b2b_data%0d[%0d]: got %h want %h", i, k, drd[k], m_rd[k]); end
      end
    end
    rd_en = 1'b0;
    step();
    n_cmp++; if (drv[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_drop: got %b want 0", drv[0]); end
    old = m_reg(0, 5'h08);
    wr_en = 1'b1; wr_addr = 5'h08; wr_data = 32'h55;
    rd_en = 1'b1; rd_addr = 5'h08;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    n_cmp++; if (drd[0] !== old) begin n_bad++; $display("FAIL rw_same_old: got %h want %h", drd[0], old); end
    rd(5'h08);
    n_cmp++; if (drd[0] !== 32'h55) begin n_bad++; $display("FAIL rw_same_new: got %h want 55", drd[0]); end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 600; i++) begin
      count_en = ($urandom_range(0, 7) != 0);
      wr_en    = ($urandom_range(0, 4) == 0);
      w        = $urandom_range(0, 7);
      wr_addr  = 5'((w << 2) | $urandom_range(0, 3));
      case (w)
        1, 3:    wr_data = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        4:       wr_data = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 5) != 0);
        default: wr_data = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 60));
      endcase
      rd_en   = $urandom_range(0, 1) != 0;
      rd_addr = 5'($urandom_range(0, 31));
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (dto[k] !== m_to[k]) begin n_bad++; $display("FAIL rand_timeout[%0d] cyc %0d: got %b want %b", k, i, dto[k], m_to[k]); end
        n_cmp++; if (drv[k] !== m_rv) begin n_bad++; $display("FAIL rand_rd_valid[%0d] cyc %0d: got %b want %b", k, i, drv[k], m_rv); end
        if (m_rv) begin
          n_cmp++; if (drd[k] !== m_rd[k]) begin n_bad++; $display("FAIL rand_rd_data[%0d] cyc %0d: got %h want %h", k, i, drd[k], m_rd[k]); end
        end
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    count_en = 1'b1;
    wr(5'h10, 32'd1);
    wr(5'h08, 32'd1);
    wr(5'h0C, 32'd0);
    repeat (3) step();
    n_cmp++; if (dto[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got %b want 1", dto[0]); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (dto[k] !== 1'b0) begin n_bad++; $display("FAIL midrst_timeout_async[%0d]: got %b want 0", k, dto[k]); end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_en = 1'b0;
    rd(5'h00);
    n_cmp++; if (drd[0] !== 32'd0) begin n_bad++; $display("FAIL midrst_mtime: got %h want 0", drd[0]); end
    rd(5'h08);
    n_cmp++; if (drd[0] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midrst_cmp_lo: got %h want ffffffff", drd[0]); end
    rd(5'h0C);
    n_cmp++; if (drd[0] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midrst_cmp_hi: got %h want ffffffff", drd[0]); end
  endtask

  initial begin
    reset = 1'b1; count_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    model_reset();
    test_reset();
    test_count_basic();
    test_prescale();
    test_carry();
    test_timeout_clear();
    test_atomic();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
